// File: rtl/det_sevenseg_driver_if.sv
// Load/handshake bundle between the determinant calculator and the seven-segment driver.
// The master presents a determinant with a one-cycle strobe; the driver reports busy.
interface det_sevenseg_driver_if;
  logic [15:0] det_in;
  logic        det_valid;
  logic        busy;

  modport master (output det_in, output det_valid, input busy);
  modport slave  (input det_in, input det_valid, output busy);
endinterface

// File: rtl/det_sevenseg_driver.sv
// Converts a signed 16-bit determinant to BCD by double-dabble and scans it onto an
// 8-digit multiplexed seven-segment display with leading-zero blanking and a minus sign.
module det_sevenseg_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                        clk,
  input  logic                        reset,
  det_sevenseg_driver_if.slave        bus,
  output logic [7:0]                  an,
  output logic [6:0]                  seg,
  output logic                        dp
);

  localparam int unsigned PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BCDW = 20;
  localparam int unsigned MAGW = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            sign_q, sign_d;
  logic [MAGW-1:0] mag_q, mag_d;
  logic [BCDW-1:0] bcd_q, bcd_d;
  logic [3:0]      iter_q, iter_d;
  logic            busy_q, busy_d;
  logic [BCDW-1:0] disp_dig_q, disp_dig_d;
  logic            disp_neg_q, disp_neg_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic [BCDW-1:0] bcd_adj;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h7F;
    endcase
  endfunction

  // Pattern for one scan position: digit up to the MSD, then '-' if negative, else blank.
  function automatic logic [6:0] seg_at(input logic [2:0] idx, input logic [BCDW-1:0] dig,
                                        input logic neg);
    logic [2:0] msd;
    msd = 3'd0;
    for (int i = 1; i < 5; i++) begin
      if (dig[i*4 +: 4] != 4'd0) msd = 3'(i);
    end
    seg_at = 7'h7F;
    if (idx <= msd)                        seg_at = enc(dig[{idx, 2'b00} +: 4]);
    else if (neg && (idx == msd + 3'd1))   seg_at = 7'h3F;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      mag_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      busy_q     <= 1'b0;
      disp_dig_q <= '0;
      disp_neg_q <= 1'b0;
      presc_q    <= '0;
      idx_q      <= '0;
      an_q       <= 8'hFE;
      seg_q      <= 7'h40;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      busy_q     <= busy_d;
      disp_dig_q <= disp_dig_d;
      disp_neg_q <= disp_neg_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  // Add-3 correction on every BCD nibble ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    busy_d     = busy_q;
    disp_dig_d = disp_dig_q;
    disp_neg_d = disp_neg_q;
    presc_d    = presc_q + PW'(1);
    idx_d      = idx_q;

    case (state_q)
      IDLE: begin
        if (bus.det_valid) begin
          sign_d  = bus.det_in[15];
          // 16'h8000 negates to itself, which is 32768 read as unsigned.
          mag_d   = bus.det_in[15] ? MAGW'(-bus.det_in) : bus.det_in;
          bcd_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        iter_d = iter_q + 4'd1;
        if (iter_q == 4'd15) state_d = LATCH;
      end
      LATCH: begin
        disp_dig_d = bcd_q;
        disp_neg_d = sign_q;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (presc_q == PW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end

    // Outputs follow the next index/display so an and seg stay aligned with the scan.
    an_d  = ~(8'd1 << idx_d);
    seg_d = seg_at(idx_d, disp_dig_d, disp_neg_d);
  end

  assign bus.busy = busy_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = 1'b1;

endmodule

// File: tb/tb_det_sevenseg_driver.sv
// Directed bench for det_sevenseg_driver with a short refresh divider.
module tb_det_sevenseg_driver;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  det_sevenseg_driver_if bus ();

  det_sevenseg_driver #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [15:0] v);
    bus.det_in    = v;
    bus.det_valid = 1'b1;
    @(negedge clk);
    bus.det_valid = 1'b0;
  endtask

  task automatic busy_len(input string tag, input int exp);
    int cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk(tag, 32'(cnt), 32'(exp));
  endtask

  task automatic wait_an(input int k);
    int t = 0;
    logic [7:0] want;
    want = ~(8'd1 << k);
    while (an !== want && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("an_idx%0d", k), 32'(an), 32'(want));
  endtask

  // exp packs the eight expected patterns as {idx7, ..., idx0}.
  task automatic show(input string tag, input logic [55:0] exp);
    for (int k = 0; k < 8; k++) begin
      wait_an(k);
      chk($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(exp[k*7 +: 7]));
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.det_in    = '0;
    bus.det_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_an",   32'(an),       32'hFE);
    chk("rst_seg",  32'(seg),      32'h40);
    chk("rst_dp",   32'(dp),       32'd1);

    // Scan rotation with an idle, zero display.
    reset = 1'b1;
    chk("rel_an",  32'(an),  32'hFE);
    chk("rel_seg", 32'(seg), 32'h40);
    for (int i = 1; i <= 8; i++) begin
      repeat (4) @(negedge clk);
      chk($sformatf("rot_an%0d", i), 32'(an), 32'(8'(~(8'd1 << (i % 8)))));
      chk($sformatf("rot_seg%0d", i), 32'(seg), (i % 8 == 0) ? 32'h40 : 32'h7F);
    end

    pulse(16'd1234);
    busy_len("busy_1234", 17);
    show("v1234", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});

    pulse(16'hFFF6);
    busy_len("busy_m10", 17);
    show("vm10", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h79, 7'h40});

    pulse(16'h8000);
    busy_len("busy_min", 17);
    show("vmin", {7'h7F, 7'h7F, 7'h3F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00});

    // Strobe during a conversion must be dropped.
    pulse(16'd5);
    repeat (4) @(negedge clk);
    pulse(16'd99);
    busy_len("busy_5_rest", 12);
    chk("busy_after_5", 32'(bus.busy), 32'd0);
    show("v5", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12});
    pulse(16'd99);
    busy_len("busy_99", 17);
    show("v99", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h10});

    // Reset in the middle of a conversion aborts it.
    pulse(16'd777);
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_an",   32'(an),       32'hFE);
    chk("abort_seg",  32'(seg),      32'h40);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_abort_busy", 32'(bus.busy), 32'd0);
    show("vabort", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});
    chk("end_dp", 32'(dp), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
